// File: rtl/axi_lite_mem_arbiter.sv
// -----------------------------------------------------------------------------
// axi_lite_mem_arbiter
//   Two-master to one-slave AXI-Lite arbiter placed in front of the shared
//   axi_lite_mem. Master 0 is the DMA core, master 1 the AES engine / CPU
//   bypass. Write and read paths are arbitrated independently; each path is
//   round-robin and stays locked to its owner for one whole transaction.
//
// Ports
//   clk, rst          : single rising-edge clock, asynchronous active-high reset
//   m0_* / m1_*       : AXI-Lite slave-side ports facing the two masters
//   s_*               : AXI-Lite master-side port facing the memory
//   wr_grant/rd_grant : one-hot owner of the write/read path, 2'b00 when idle
// -----------------------------------------------------------------------------
module axi_lite_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_awvalid,
  input  logic [ADDR_WIDTH-1:0] m0_awaddr,
  output logic                  m0_awready,
  input  logic                  m0_wvalid,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_wready,
  output logic                  m0_bvalid,
  input  logic                  m0_bready,
  input  logic                  m0_arvalid,
  input  logic [ADDR_WIDTH-1:0] m0_araddr,
  output logic                  m0_arready,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m0_rready,
  input  logic                  m1_awvalid,
  input  logic [ADDR_WIDTH-1:0] m1_awaddr,
  output logic                  m1_awready,
  input  logic                  m1_wvalid,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_wready,
  output logic                  m1_bvalid,
  input  logic                  m1_bready,
  input  logic                  m1_arvalid,
  input  logic [ADDR_WIDTH-1:0] m1_araddr,
  output logic                  m1_arready,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  input  logic                  m1_rready,
  output logic                  s_awvalid,
  output logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic                  s_awready,
  output logic                  s_wvalid,
  output logic [DATA_WIDTH-1:0] s_wdata,
  input  logic                  s_wready,
  input  logic                  s_bvalid,
  output logic                  s_bready,
  output logic                  s_arvalid,
  output logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic                  s_arready,
  input  logic                  s_rvalid,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  output logic                  s_rready,
  output logic [1:0]            wr_grant,
  output logic [1:0]            rd_grant
);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_XFER = 2'd1, W_RESP = 2'd2} wr_state_e;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rd_state_e;

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;
  logic [1:0] wr_grant_q, wr_grant_d, rd_grant_q, rd_grant_d;
  // Pointer value 0 favours m0 on a tie, 1 favours m1.
  logic wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;

  // Signals of whichever master currently owns each path (zero when idle).
  logic                  g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;
  logic [ADDR_WIDTH-1:0] g_awaddr, g_araddr;
  logic [DATA_WIDTH-1:0] g_wdata;

  assign wr_grant = wr_grant_q;
  assign rd_grant = rd_grant_q;

  // State, grant, pointer and handshake-flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      wr_grant_q <= 2'b00;
      rd_grant_q <= 2'b00;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      wr_grant_q <= wr_grant_d;
      rd_grant_q <= rd_grant_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  // Owner muxes: select purely on the registered grant, so an idle path
  // never forms a combinational path from a master to the memory.
  always_comb begin
    g_awvalid = 1'b0; g_awaddr = {ADDR_WIDTH{1'b0}};
    g_wvalid  = 1'b0; g_wdata  = {DATA_WIDTH{1'b0}};
    g_bready  = 1'b0;
    g_arvalid = 1'b0; g_araddr = {ADDR_WIDTH{1'b0}};
    g_rready  = 1'b0;
    case (wr_grant_q)
      2'b01: begin
        g_awvalid = m0_awvalid; g_awaddr = m0_awaddr;
        g_wvalid  = m0_wvalid;  g_wdata  = m0_wdata;  g_bready = m0_bready;
      end
      2'b10: begin
        g_awvalid = m1_awvalid; g_awaddr = m1_awaddr;
        g_wvalid  = m1_wvalid;  g_wdata  = m1_wdata;  g_bready = m1_bready;
      end
      default: ;
    endcase
    case (rd_grant_q)
      2'b01: begin
        g_arvalid = m0_arvalid; g_araddr = m0_araddr; g_rready = m0_rready;
      end
      2'b10: begin
        g_arvalid = m1_arvalid; g_araddr = m1_araddr; g_rready = m1_rready;
      end
      default: ;
    endcase
  end

  // Write FSM: arbitration on awvalid, AW/W transfer with sticky flags, B return.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_grant_d = wr_grant_q;
    wr_ptr_d   = wr_ptr_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    s_awvalid  = 1'b0; s_awaddr = {ADDR_WIDTH{1'b0}};
    s_wvalid   = 1'b0; s_wdata  = {DATA_WIDTH{1'b0}};
    s_bready   = 1'b0;
    m0_awready = 1'b0; m0_wready = 1'b0; m0_bvalid = 1'b0;
    m1_awready = 1'b0; m1_wready = 1'b0; m1_bvalid = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (m0_awvalid && m1_awvalid) begin
          wr_grant_d = wr_ptr_q ? 2'b10 : 2'b01;
          wr_state_d = W_XFER;
        end else if (m0_awvalid) begin
          wr_grant_d = 2'b01;
          wr_state_d = W_XFER;
        end else if (m1_awvalid) begin
          wr_grant_d = 2'b10;
          wr_state_d = W_XFER;
        end else begin
          wr_state_d = W_IDLE;
        end
      end
      W_XFER: begin
        // A channel that has already handshaken is masked so it is never replayed.
        s_awvalid  = g_awvalid & ~aw_done_q;
        s_awaddr   = g_awaddr;
        s_wvalid   = g_wvalid & ~w_done_q;
        s_wdata    = g_wdata;
        m0_awready = wr_grant_q[0] & s_awready & ~aw_done_q;
        m1_awready = wr_grant_q[1] & s_awready & ~aw_done_q;
        m0_wready  = wr_grant_q[0] & s_wready & ~w_done_q;
        m1_wready  = wr_grant_q[1] & s_wready & ~w_done_q;
        aw_done_d  = aw_done_q | (g_awvalid & s_awready);
        w_done_d   = w_done_q | (g_wvalid & s_wready);
        if (aw_done_q && w_done_q) begin
          wr_state_d = W_RESP;
        end else begin
          wr_state_d = W_XFER;
        end
      end
      W_RESP: begin
        m0_bvalid = wr_grant_q[0] & s_bvalid;
        m1_bvalid = wr_grant_q[1] & s_bvalid;
        s_bready  = g_bready;
        if (s_bvalid && g_bready) begin
          wr_state_d = W_IDLE;
          wr_grant_d = 2'b00;
          wr_ptr_d   = wr_grant_q[0];  // favour the master that was not served
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
        end else begin
          wr_state_d = W_RESP;
        end
      end
      default: begin
        wr_state_d = W_IDLE;
        wr_grant_d = 2'b00;
        aw_done_d  = 1'b0;
        w_done_d   = 1'b0;
      end
    endcase
  end

  // Read FSM: arbitration on arvalid, AR transfer, R return.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_grant_d = rd_grant_q;
    rd_ptr_d   = rd_ptr_q;
    s_arvalid  = 1'b0; s_araddr = {ADDR_WIDTH{1'b0}};
    s_rready   = 1'b0;
    m0_arready = 1'b0; m0_rvalid = 1'b0; m0_rdata = {DATA_WIDTH{1'b0}};
    m1_arready = 1'b0; m1_rvalid = 1'b0; m1_rdata = {DATA_WIDTH{1'b0}};
    case (rd_state_q)
      R_IDLE: begin
        if (m0_arvalid && m1_arvalid) begin
          rd_grant_d = rd_ptr_q ? 2'b10 : 2'b01;
          rd_state_d = R_ADDR;
        end else if (m0_arvalid) begin
          rd_grant_d = 2'b01;
          rd_state_d = R_ADDR;
        end else if (m1_arvalid) begin
          rd_grant_d = 2'b10;
          rd_state_d = R_ADDR;
        end else begin
          rd_state_d = R_IDLE;
        end
      end
      R_ADDR: begin
        s_arvalid  = g_arvalid;
        s_araddr   = g_araddr;
        m0_arready = rd_grant_q[0] & s_arready;
        m1_arready = rd_grant_q[1] & s_arready;
        if (g_arvalid && s_arready) begin
          rd_state_d = R_DATA;
        end else begin
          rd_state_d = R_ADDR;
        end
      end
      R_DATA: begin
        m0_rvalid = rd_grant_q[0] & s_rvalid;
        m1_rvalid = rd_grant_q[1] & s_rvalid;
        m0_rdata  = rd_grant_q[0] ? s_rdata : {DATA_WIDTH{1'b0}};
        m1_rdata  = rd_grant_q[1] ? s_rdata : {DATA_WIDTH{1'b0}};
        s_rready  = g_rready;
        if (s_rvalid && g_rready) begin
          rd_state_d = R_IDLE;
          rd_grant_d = 2'b00;
          rd_ptr_d   = rd_grant_q[0];
        end else begin
          rd_state_d = R_DATA;
        end
      end
      default: begin
        rd_state_d = R_IDLE;
        rd_grant_d = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// Testbench for axi_lite_mem_arbiter: behavioural memory slave, two master
// driver tasks, a reference memory array and a scoreboard monitor that
// checks every B/R handshake against expectations queued at issue time.
module tb_axi_lite_mem_arbiter;

  typedef struct packed {logic [31:0] a; logic [31:0] d;} wr_t;

  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Master-side stimulus and responses, indexed by master number.
  logic        awvalid [2];
  logic [31:0] awaddr  [2];
  logic        wvalid  [2];
  logic [31:0] wdata   [2];
  logic        bready  [2];
  logic        arvalid [2];
  logic [31:0] araddr  [2];
  logic        rready  [2];
  logic        awready [2];
  logic        wready  [2];
  logic        bvalid  [2];
  logic        arready [2];
  logic        rvalid  [2];
  logic [31:0] rdata   [2];

  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [1:0]  wr_grant, rd_grant;

  axi_lite_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .m0_awvalid(awvalid[0]), .m0_awaddr(awaddr[0]), .m0_awready(awready[0]),
    .m0_wvalid(wvalid[0]), .m0_wdata(wdata[0]), .m0_wready(wready[0]),
    .m0_bvalid(bvalid[0]), .m0_bready(bready[0]),
    .m0_arvalid(arvalid[0]), .m0_araddr(araddr[0]), .m0_arready(arready[0]),
    .m0_rvalid(rvalid[0]), .m0_rdata(rdata[0]), .m0_rready(rready[0]),
    .m1_awvalid(awvalid[1]), .m1_awaddr(awaddr[1]), .m1_awready(awready[1]),
    .m1_wvalid(wvalid[1]), .m1_wdata(wdata[1]), .m1_wready(wready[1]),
    .m1_bvalid(bvalid[1]), .m1_bready(bready[1]),
    .m1_arvalid(arvalid[1]), .m1_araddr(araddr[1]), .m1_arready(arready[1]),
    .m1_rvalid(rvalid[1]), .m1_rdata(rdata[1]), .m1_rready(rready[1]),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rready(s_rready),
    .wr_grant(wr_grant), .rd_grant(rd_grant)
  );

  // Every DUT-driven valid/ready, slave address/data and read data, OR-reduced.
  logic any_out;
  assign any_out = |{awready[0], awready[1], wready[0], wready[1], bvalid[0], bvalid[1],
                     arready[0], arready[1], rvalid[0], rvalid[1], s_awvalid, s_wvalid,
                     s_bready, s_arvalid, s_rready, s_awaddr, s_wdata, s_araddr,
                     rdata[0], rdata[1]};

  // ---------------- behavioural memory slave ----------------
  logic [31:0] smem [256];
  logic        aw_have, w_have;
  logic [31:0] aw_a, w_d, last_a, last_d;
  int          dup_aw, dup_w, dup_ar, wr_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_awready <= 1'b0; s_wready <= 1'b0; s_arready <= 1'b0;
      s_bvalid <= 1'b0; s_rvalid <= 1'b0; s_rdata <= 32'h0;
      aw_have <= 1'b0; w_have <= 1'b0; aw_a <= 32'h0; w_d <= 32'h0;
      last_a <= 32'h0; last_d <= 32'h0;
      dup_aw <= 0; dup_w <= 0; dup_ar <= 0; wr_cnt <= 0;
      for (int k = 0; k < 256; k++) smem[k] <= 32'h0;
    end else begin
      s_awready <= ($urandom_range(0, 3) != 0);
      s_wready  <= ($urandom_range(0, 3) != 0);
      s_arready <= ($urandom_range(0, 3) != 0);
      if (s_awvalid && s_awready) begin
        if (aw_have) dup_aw <= dup_aw + 1;
        aw_have <= 1'b1; aw_a <= s_awaddr;
      end
      if (s_wvalid && s_wready) begin
        if (w_have) dup_w <= dup_w + 1;
        w_have <= 1'b1; w_d <= s_wdata;
      end
      if (aw_have && w_have && !s_bvalid) begin
        smem[aw_a[9:2]] <= w_d;
        last_a <= aw_a; last_d <= w_d;
        wr_cnt <= wr_cnt + 1;
        s_bvalid <= 1'b1; aw_have <= 1'b0; w_have <= 1'b0;
      end
      if (s_bvalid && s_bready) s_bvalid <= 1'b0;
      if (s_arvalid && s_arready) begin
        if (s_rvalid) dup_ar <= dup_ar + 1;
        s_rvalid <= 1'b1; s_rdata <= smem[s_araddr[9:2]];
      end else if (s_rvalid && s_rready) begin
        s_rvalid <= 1'b0;
      end
    end
  end

  // ---------------- reference model and scoreboard ----------------
  logic [31:0] ref_mem [256];
  wr_t         exp_b0[$], exp_b1[$];
  logic [31:0] exp_r0[$], exp_r1[$];
  logic [1:0]  wr_order[$], rd_order[$];
  logic [1:0]  prev_wr, prev_rd;
  bit          conc_seen;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
  endtask

  function automatic logic [1:0] onehot(input int m);
    return (m == 0) ? 2'b01 : 2'b10;
  endfunction

  // Monitor: sample half a cycle away from the active edge.
  initial begin
    wr_t         e;
    logic [31:0] er;
    int          sz;
    prev_wr = 2'b00; prev_rd = 2'b00; conc_seen = 1'b0;
    forever begin
      @(negedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (bvalid[i] && bready[i]) begin
          sz = (i == 0) ? exp_b0.size() : exp_b1.size();
          chk("b_pending", (sz != 0), 1'b1);
          if (sz != 0) begin
            e = (i == 0) ? exp_b0.pop_front() : exp_b1.pop_front();
            chk("b_waddr", last_a, e.a);
            chk("b_wdata", last_d, e.d);
            chk("b_grant", wr_grant, onehot(i));
          end
        end
        if (rvalid[i] && rready[i]) begin
          sz = (i == 0) ? exp_r0.size() : exp_r1.size();
          chk("r_pending", (sz != 0), 1'b1);
          if (sz != 0) begin
            er = (i == 0) ? exp_r0.pop_front() : exp_r1.pop_front();
            chk("rdata", rdata[i], er);
            chk("r_grant", rd_grant, onehot(i));
          end
        end
      end
      // Non-owners see no ready/valid; an idle path drives nothing to memory.
      chk("excl", {awready[0] & ~wr_grant[0], awready[1] & ~wr_grant[1],
                   wready[0] & ~wr_grant[0], wready[1] & ~wr_grant[1],
                   bvalid[0] & ~wr_grant[0], bvalid[1] & ~wr_grant[1],
                   arready[0] & ~rd_grant[0], arready[1] & ~rd_grant[1],
                   rvalid[0] & ~rd_grant[0], rvalid[1] & ~rd_grant[1],
                   (wr_grant == 2'b00) & (s_awvalid | s_wvalid | s_bready),
                   (rd_grant == 2'b00) & (s_arvalid | s_rready),
                   (wr_grant == 2'b11), (rd_grant == 2'b11)}, 64'h0);
      if (wr_grant != 2'b00 && prev_wr == 2'b00) wr_order.push_back(wr_grant);
      if (rd_grant != 2'b00 && prev_rd == 2'b00) rd_order.push_back(rd_grant);
      if (wr_grant == 2'b10 && rd_grant == 2'b01) conc_seen = 1'b1;
      prev_wr = wr_grant; prev_rd = rd_grant;
    end
  end

  // ---------------- master driver tasks ----------------
  task automatic mwrite(input int m, input logic [31:0] a, input logic [31:0] d, input int lead);
    bit  awd, wd, haw, hw, hb;
    int  t;
    wr_t e;
    awd = 1'b0; wd = 1'b0; hb = 1'b0; t = 0;
    @(negedge clk);
    wvalid[m] = 1'b1; wdata[m] = d;
    for (int k = 0; k < lead; k++) begin
      #1;
      chk("lead_no_grant", wr_grant, 2'b00);
      chk("lead_no_s_wvalid", s_wvalid, 1'b0);
      @(negedge clk);
    end
    awvalid[m] = 1'b1; awaddr[m] = a;
    ref_mem[a[9:2]] = d;
    e.a = a; e.d = d;
    if (m == 0) exp_b0.push_back(e); else exp_b1.push_back(e);
    while (!(awd && wd) && t < 400) begin
      #1;
      haw = awvalid[m] && awready[m];
      hw  = wvalid[m] && wready[m];
      @(negedge clk); t++;
      if (haw) begin awvalid[m] = 1'b0; awd = 1'b1; end
      if (hw)  begin wvalid[m]  = 1'b0; wd  = 1'b1; end
    end
    bready[m] = 1'b1;
    while (!hb && t < 400) begin
      #1; hb = bvalid[m] && bready[m];
      @(negedge clk); t++;
    end
    bready[m] = 1'b0;
    chk("wr_in_budget", (t < 400), 1'b1);
  endtask

  task automatic mread(input int m, input logic [31:0] a, input int dly);
    bit har, hr;
    int t;
    har = 1'b0; hr = 1'b0; t = 0;
    @(negedge clk);
    arvalid[m] = 1'b1; araddr[m] = a;
    if (m == 0) exp_r0.push_back(ref_mem[a[9:2]]); else exp_r1.push_back(ref_mem[a[9:2]]);
    while (!har && t < 400) begin
      #1; har = arvalid[m] && arready[m];
      @(negedge clk); t++;
    end
    arvalid[m] = 1'b0;
    for (int k = 0; k < dly; k++) begin
      #1;
      chk("bp_s_rready", s_rready, 1'b0);
      chk("bp_rd_grant", rd_grant, onehot(m));
      @(negedge clk); t++;
    end
    rready[m] = 1'b1;
    while (!hr && t < 400) begin
      #1; hr = rvalid[m] && rready[m];
      @(negedge clk); t++;
    end
    rready[m] = 1'b0;
    chk("rd_in_budget", (t < 400), 1'b1);
  endtask

  task automatic clear_model();
    for (int k = 0; k < 256; k++) ref_mem[k] = 32'h0;
    exp_b0.delete(); exp_b1.delete(); exp_r0.delete(); exp_r1.delete();
    wr_order.delete(); rd_order.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      awvalid[i] = 1'b0; awaddr[i] = 32'h0; wvalid[i] = 1'b0; wdata[i] = 32'h0;
      bready[i] = 1'b0; arvalid[i] = 1'b0; araddr[i] = 32'h0; rready[i] = 1'b0;
    end
    clear_model();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_grants", {wr_grant, rd_grant}, 4'b0000);
    chk("rst_outputs_quiet", any_out, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int wc0;
    do_reset();

    // Single write by m0, then readback through m1.
    fork
      mwrite(0, 32'h10, 32'hDEADBEEF, 0);
      begin
        @(negedge clk); #1;
        chk("t1_grant_before", wr_grant, 2'b00);
        @(negedge clk); #1;
        chk("t1_grant_after", wr_grant, 2'b01);
        chk("t1_s_awaddr", s_awaddr, 32'h10);
      end
    join
    #1; chk("t1_grant_released", wr_grant, 2'b00);
    mread(1, 32'h10, 0);

    // Simultaneous writes: m0, then pending m1 beats m0's repeat.
    do_reset();
    fork
      begin
        mwrite(0, 32'h50, 32'h1111_0050, 0);
        mwrite(0, 32'h54, 32'h1111_0054, 0);
      end
      mwrite(1, 32'h60, 32'h2222_0060, 0);
    join
    chk("t2_order_len", wr_order.size(), 3);
    if (wr_order.size() == 3) begin
      chk("t2_order0", wr_order[0], 2'b01);
      chk("t2_order1", wr_order[1], 2'b10);
      chk("t2_order2", wr_order[2], 2'b01);
    end

    // W before AW: no grant until awvalid, data written exactly once.
    wc0 = wr_cnt;
    mwrite(1, 32'h30, 32'hCAFE_0030, 3);
    chk("t3_write_count", wr_cnt - wc0, 1);
    mread(0, 32'h30, 0);

    // Concurrent read (m0) and write (m1).
    mwrite(0, 32'h20, 32'h0BAD_0020, 0);
    conc_seen = 1'b0;
    fork
      mread(0, 32'h20, 0);
      mwrite(1, 32'h24, 32'h0BAD_0024, 0);
    join
    chk("t4_concurrent_grants", conc_seen, 1'b1);
    mread(1, 32'h20, 0);
    mread(0, 32'h24, 0);

    // Read backpressure: m0 stalls rready, m1's read waits for it.
    rd_order.delete();
    fork
      mread(0, 32'h30, 5);
      begin
        repeat (2) @(negedge clk);
        mread(1, 32'h24, 0);
      end
    join
    chk("t5_order_len", rd_order.size(), 2);
    if (rd_order.size() == 2) begin
      chk("t5_order0", rd_order[0], 2'b01);
      chk("t5_order1", rd_order[1], 2'b10);
    end

    // Reset in W_RESP aborts the write with everything quiet.
    @(negedge clk);
    awvalid[1] = 1'b1; awaddr[1] = 32'h44; wvalid[1] = 1'b1; wdata[1] = 32'hA5A5_0044;
    bready[1] = 1'b0;
    t = 0;
    while (!(s_bvalid && wr_grant == 2'b10) && t < 200) begin
      @(negedge clk); t++;
    end
    chk("t6_in_resp", (s_bvalid && wr_grant == 2'b10), 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_grants", {wr_grant, rd_grant}, 4'b0000);
    chk("t6_rst_quiet", any_out, 1'b0);
    awvalid[1] = 1'b0; wvalid[1] = 1'b0;
    clear_model();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mwrite(1, 32'h48, 32'h5A5A_0048, 0);
    chk("t6_regrant_len", wr_order.size(), 1);
    if (wr_order.size() == 1) chk("t6_regrant", wr_order[0], 2'b10);
    mread(0, 32'h48, 0);

    // Randomized traffic: each master in its own word region.
    fork
      begin
        for (int i = 0; i < 25; i++) begin
          int unsigned wa0;
          wa0 = $urandom_range(64, 127);
          if ($urandom_range(0, 1) == 0) mwrite(0, wa0 << 2, $urandom, 0);
          else mread(0, wa0 << 2, $urandom_range(0, 3));
        end
      end
      begin
        for (int j = 0; j < 25; j++) begin
          int unsigned wa1;
          wa1 = $urandom_range(128, 191);
          if ($urandom_range(0, 1) == 0) mwrite(1, wa1 << 2, $urandom, 0);
          else mread(1, wa1 << 2, $urandom_range(0, 3));
        end
      end
    join

    repeat (3) @(negedge clk);
    #1;
    chk("final_b_queues_empty", exp_b0.size() + exp_b1.size(), 0);
    chk("final_r_queues_empty", exp_r0.size() + exp_r1.size(), 0);
    chk("no_duplicate_aw", dup_aw, 0);
    chk("no_duplicate_w", dup_w, 0);
    chk("no_duplicate_ar", dup_ar, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
